// File: rtl/alu_issue_seq.sv
// ALU command sequencer: accept -> EX (drives the ALU) -> RSP, with an internal
// register file, result forwarding into the accept stage, and a sticky overflow flag.
module alu_issue_seq #(
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [4:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_rd_i,
  input  logic [AW-1:0] cmd_rs_i,
  input  logic [AW-1:0] cmd_rt_i,
  input  logic          cmd_imm_en_i,
  input  logic [15:0]   cmd_imm_i,
  output logic [15:0]   alu_a_o,
  output logic [15:0]   alu_b_o,
  output logic [4:0]    alu_ctrl_o,
  input  logic [15:0]   alu_out_i,
  input  logic          alu_ovfl_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [AW-1:0] rsp_rd_o,
  output logic [15:0]   rsp_data_o,
  output logic          rsp_ovfl_o,
  output logic          rsp_err_o,
  output logic          ovfl_sticky_o,
  input  logic          ovfl_clr_i,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [15:0]   dbg_data_o
);

  function automatic logic op_legal(input logic [4:0] op);
    return (op <= 5'h6) || ((op >= 5'h8) && (op <= 5'hB));
  endfunction

  logic          ex_valid_q, ex_valid_d;
  logic [15:0]   ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic [4:0]    ex_op_q, ex_op_d;
  logic [AW-1:0] ex_rd_q, ex_rd_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [AW-1:0] rsp_rd_q, rsp_rd_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_ovfl_q, rsp_ovfl_d, rsp_err_q, rsp_err_d;
  logic          sticky_q, sticky_d;
  logic [NREGS-1:0][15:0] rf_q;

  logic stall, ex_adv, ex_legal, wr_en, accept;
  logic [15:0] opa, opb;

  assign stall       = rsp_valid_q & ~rsp_ready_i;
  assign ex_adv      = ex_valid_q & ~stall;
  assign ex_legal    = op_legal(ex_op_q);
  assign wr_en       = ex_adv & ex_legal & (ex_rd_q != '0);
  assign cmd_ready_o = ~(ex_valid_q & stall);
  assign accept      = cmd_valid_i & cmd_ready_o;

  // Operands bypass the file when the EX result is being written this same edge.
  assign opa = (wr_en && (cmd_rs_i == ex_rd_q)) ? alu_out_i : rf_q[cmd_rs_i];
  assign opb = cmd_imm_en_i ? cmd_imm_i :
               (wr_en && (cmd_rt_i == ex_rd_q)) ? alu_out_i : rf_q[cmd_rt_i];

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_a_d      = ex_a_q;
    ex_b_d      = ex_b_q;
    ex_op_d     = ex_op_q;
    ex_rd_d     = ex_rd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovfl_d  = rsp_ovfl_q;
    rsp_err_d   = rsp_err_q;
    sticky_d    = sticky_q;

    if (accept) begin
      ex_valid_d = 1'b1;
      ex_a_d     = opa;
      ex_b_d     = opb;
      ex_op_d    = cmd_op_i;
      ex_rd_d    = cmd_rd_i;
    end else if (ex_adv) begin
      ex_valid_d = 1'b0;
    end

    if (ex_adv) begin
      rsp_valid_d = 1'b1;
      rsp_rd_d    = ex_rd_q;
      rsp_data_d  = ex_legal ? alu_out_i : 16'h0;
      rsp_ovfl_d  = ex_legal & alu_ovfl_i;
      rsp_err_d   = ~ex_legal;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end

    // A same-cycle overflow beats the clear.
    if (ex_adv && ex_legal && alu_ovfl_i) sticky_d = 1'b1;
    else if (ovfl_clr_i)                  sticky_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q  <= 1'b0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_op_q     <= '0;
      ex_rd_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ovfl_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      sticky_q    <= 1'b0;
      rf_q        <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovfl_q  <= rsp_ovfl_d;
      rsp_err_q   <= rsp_err_d;
      sticky_q    <= sticky_d;
      if (wr_en) rf_q[ex_rd_q] <= alu_out_i;
    end
  end

  assign alu_a_o       = ex_a_q;
  assign alu_b_o       = ex_b_q;
  assign alu_ctrl_o    = ex_op_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rd_o      = rsp_rd_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_ovfl_o    = rsp_ovfl_q;
  assign rsp_err_o     = rsp_err_q;
  assign ovfl_sticky_o = sticky_q;
  assign dbg_data_o    = rf_q[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU, sequential register-file model feeding
// a response scoreboard, plus directed checks for stall, overflow, R0 and reset.
module tb_alu_issue_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [4:0] cmd_op = '0;
  logic [3:0] cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
  logic cmd_imm_en = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [4:0] alu_ctrl;
  logic alu_ovfl;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [3:0] rsp_rd;
  logic [15:0] rsp_data;
  logic rsp_ovfl, rsp_err, ovfl_sticky, ovfl_clr = 1'b0;
  logic [3:0] dbg_addr = '0;
  logic [15:0] dbg_data;

  typedef struct packed {logic [3:0] rd; logic [15:0] data; logic ovfl; logic err;} rsp_t;
  rsp_t sbq[$];
  logic [15:0] mreg [16];
  logic msticky = 1'b0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_rd_i(cmd_rd), .cmd_rs_i(cmd_rs), .cmd_rt_i(cmd_rt),
    .cmd_imm_en_i(cmd_imm_en), .cmd_imm_i(cmd_imm),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl),
    .alu_out_i(alu_out), .alu_ovfl_i(alu_ovfl),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rd_o(rsp_rd),
    .rsp_data_o(rsp_data), .rsp_ovfl_o(rsp_ovfl), .rsp_err_o(rsp_err),
    .ovfl_sticky_o(ovfl_sticky), .ovfl_clr_i(ovfl_clr),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  function automatic logic [16:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic o;
    r = '0;
    o = 1'b0;
    case (op)
      5'h0, 5'hA, 5'hB: begin r = a + b; o = (a[15] == b[15]) && (r[15] != a[15]); end
      5'h1: begin r = a - b; o = (a[15] != b[15]) && (r[15] != a[15]); end
      5'h2: r = a & b;
      5'h3: r = a | b;
      5'h4: r = a ^ b;
      5'h5: r = a << b[3:0];
      5'h6: r = $unsigned($signed(a) >>> b[3:0]);
      5'h8: r = {a[15:8], b[7:0]};
      5'h9: r = {b[7:0], a[7:0]};
      default: r = 16'hDEAD;
    endcase
    return {o, r};
  endfunction

  function automatic bit legal_f(input logic [4:0] op);
    return (op <= 5'h6) || (op >= 5'h8 && op <= 5'hB);
  endfunction

  always_comb {alu_ovfl, alu_out} = alu_f(alu_ctrl, alu_a, alu_b);

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic ie, input logic [15:0] imm);
    logic [15:0] a, b;
    logic [16:0] r;
    rsp_t e;
    bit done;
    done = 0;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (cmd_ready) begin
        @(posedge clk);
        a = mreg[rs];
        b = ie ? imm : mreg[rt];
        e.rd = rd;
        if (legal_f(op)) begin
          r = alu_f(op, a, b);
          e.data = r[15:0]; e.ovfl = r[16]; e.err = 1'b0;
          if (rd != 0) mreg[rd] = r[15:0];
          if (r[16]) msticky = 1'b1;
        end else begin
          e.data = '0; e.ovfl = 1'b0; e.err = 1'b1;
        end
        sbq.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL send_timeout op=%h got=no_accept exp=accept", op); end
  endtask

  task automatic collect(input int n, input bit rnd);
    int got;
    rsp_t e;
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      #1;
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++; $display("FAIL rsp_unexpected got=%h exp=none", {rsp_rd, rsp_data, rsp_ovfl, rsp_err});
        end else begin
          e = sbq.pop_front();
          if ({rsp_rd, rsp_data, rsp_ovfl, rsp_err} !== e) begin
            n_bad++;
            $display("FAIL rsp got rd=%h data=%h ovfl=%b err=%b exp rd=%h data=%h ovfl=%b err=%b",
                     rsp_rd, rsp_data, rsp_ovfl, rsp_err, e.rd, e.data, e.ovfl, e.err);
          end
        end
        got++;
      end
      @(negedge clk);
      if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
    end
    rsp_ready = 1'b1;
    n_cmp++;
    if (got < n) begin n_bad++; $display("FAIL collect_timeout got=%0d exp=%0d", got, n); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, ovfl_sticky} !== 3'b100) begin
      n_bad++; $display("FAIL reset_ctl got=%b exp=100", {cmd_ready, rsp_valid, ovfl_sticky});
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl, rsp_data} !== '0) begin
      n_bad++; $display("FAIL reset_data got=%h exp=0", {alu_a, alu_b, alu_ctrl, rsp_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_llb_lhb;
    fork
      begin send(5'h8, 1, 1, 0, 1, 16'h0034); send(5'h9, 1, 1, 0, 1, 16'h0012); end
      collect(2, 0);
    join
    dbg_addr = 1;
    #1;
    n_cmp++;
    if (dbg_data !== 16'h1234) begin n_bad++; $display("FAIL dbg_r1 got=%h exp=1234", dbg_data); end
    @(negedge clk);
  endtask

  task automatic test_ovfl;
    fork
      begin
        send(5'h8, 2, 2, 0, 1, 16'h00FF);
        send(5'h9, 2, 2, 0, 1, 16'h007F);
        send(5'h0, 3, 2, 0, 1, 16'h0001);
      end
      collect(3, 0);
    join
    #1;
    n_cmp++;
    if (ovfl_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set got=%b exp=1", ovfl_sticky); end
    @(negedge clk);
    ovfl_clr = 1'b1;
    @(negedge clk);
    ovfl_clr = 1'b0;
    msticky = 1'b0;
    #1;
    n_cmp++;
    if (ovfl_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clr got=%b exp=0", ovfl_sticky); end
    @(negedge clk);
    fork
      begin
        send(5'h0, 3, 2, 0, 1, 16'h0001);
        ovfl_clr = 1'b1;
        @(negedge clk);
        ovfl_clr = 1'b0;
      end
      collect(1, 0);
    join
    #1;
    n_cmp++;
    if (ovfl_sticky !== msticky) begin n_bad++; $display("FAIL sticky_set_wins got=%b exp=%b", ovfl_sticky, msticky); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    ovfl_clr = 1'b1;
    @(negedge clk);
    ovfl_clr = 1'b0;
    msticky = 1'b0;
    fork
      begin
        send(5'h8, 4, 4, 0, 1, 16'h00AA);
        send(5'h7, 4, 4, 4, 0, 16'h0000);
        send(5'h1F, 4, 4, 0, 1, 16'h7FFF);
      end
      collect(3, 0);
    join
    dbg_addr = 4;
    #1;
    n_cmp++;
    if (dbg_data !== 16'h00AA) begin n_bad++; $display("FAIL illegal_nowb got=%h exp=00aa", dbg_data); end
    n_cmp++;
    if (ovfl_sticky !== msticky) begin n_bad++; $display("FAIL illegal_sticky got=%b exp=%b", ovfl_sticky, msticky); end
    @(negedge clk);
  endtask

  task automatic test_r0;
    fork
      begin
        send(5'h8, 8, 8, 0, 1, 16'h0005);
        send(5'h8, 9, 9, 0, 1, 16'h0003);
        send(5'h1, 0, 8, 9, 0, 16'h0000);
        send(5'h0, 10, 0, 0, 1, 16'h0007);
      end
      collect(4, 0);
    join
    dbg_addr = 0;
    #1;
    n_cmp++;
    if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL dbg_r0 got=%h exp=0000", dbg_data); end
    dbg_addr = 10;
    #1;
    n_cmp++;
    if (dbg_data !== 16'h0007) begin n_bad++; $display("FAIL r0_read got=%h exp=0007", dbg_data); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    rsp_t h;
    rsp_ready = 1'b0;
    send(5'h0, 5, 0, 0, 1, 16'h0011);
    send(5'h4, 6, 5, 0, 1, 16'h00F0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready got=%b exp=0", cmd_ready); end
      n_cmp++;
      if ({alu_a, alu_b, alu_ctrl} !== {16'h0011, 16'h00F0, 5'h4}) begin
        n_bad++; $display("FAIL stall_alu got=%h/%h/%h exp=0011/00f0/04", alu_a, alu_b, alu_ctrl);
      end
      h = sbq[0];
      n_cmp++;
      if ({rsp_valid, rsp_rd, rsp_data, rsp_ovfl, rsp_err} !== {1'b1, h}) begin
        n_bad++; $display("FAIL stall_rsp got=%b/%h/%h exp=1/%h/%h", rsp_valid, rsp_rd, rsp_data, h.rd, h.data);
      end
      @(negedge clk);
    end
    fork
      send(5'h1, 7, 6, 5, 0, 16'h0000);
      begin rsp_ready = 1'b1; collect(3, 0); end
    join
  endtask

  task automatic test_random;
    logic [4:0] ops [12];
    ops = '{5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6, 5'h8, 5'h9, 5'hA, 5'hB, 5'h0C};
    fork
      for (int i = 0; i < 24; i++)
        send(ops[$urandom_range(0, 11)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom()));
      collect(24, 1);
    join
    #1;
    n_cmp++;
    if (ovfl_sticky !== msticky) begin n_bad++; $display("FAIL rand_sticky got=%b exp=%b", ovfl_sticky, msticky); end
    @(negedge clk);
  endtask

  task automatic test_reset_stall;
    bit seen;
    rsp_ready = 1'b0;
    send(5'h0, 11, 0, 0, 1, 16'h0055);
    send(5'h0, 12, 11, 0, 1, 16'h0001);
    dbg_addr = 11;
    #1;
    n_cmp++;
    if (dbg_data !== 16'h0055) begin n_bad++; $display("FAIL pre_reset_r11 got=%h exp=0055", dbg_data); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rd, rsp_data, rsp_ovfl, rsp_err, ovfl_sticky} !== '0) begin
      n_bad++; $display("FAIL midreset_rsp got=%b/%h/%h/%b/%b/%b exp=0", rsp_valid, rsp_rd, rsp_data, rsp_ovfl, rsp_err, ovfl_sticky);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl, cmd_ready} !== {37'h0, 1'b1}) begin
      n_bad++; $display("FAIL midreset_alu got=%h/%h/%h/%b exp=0/0/0/1", alu_a, alu_b, alu_ctrl, cmd_ready);
    end
    n_cmp++;
    if (dbg_data !== 16'h0) begin n_bad++; $display("FAIL midreset_rf got=%h exp=0000", dbg_data); end
    sbq.delete();
    foreach (mreg[i]) mreg[i] = '0;
    msticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (rsp_valid) seen = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL dropped_rsp got=valid exp=none"); end
  endtask

  initial begin
    foreach (mreg[i]) mreg[i] = '0;
    test_reset();
    test_llb_lhb();
    test_ovfl();
    test_illegal();
    test_r0();
    test_stall();
    test_random();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
